// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int WIDTH_DEF = 16;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/fulladder.sv
// Gate-level one-bit full adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p, g, t;

  xor (p, a, b);
  xor (s, p, ci);
  and (g, a, b);
  and (t, p, ci);
  or  (co, g, t);
endmodule

// File: rtl/serial_add16.sv
// Bit-serial adder: one bit per clock, LSB first, valid/ready on both sides.
module serial_add16
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s, co;

  fulladder u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(s), .co(co));

  // acc holds the sum bits produced so far; the final bit is merged straight
  // into sum so the result register only changes on the last RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr     <= a;
          b_sr     <= b;
          carry    <= cin;
          cnt      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          acc   <= (WIDTH-1)'({s, acc} >> 1);
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= co;
          if (cnt == LAST) begin
            sum       <= {s, acc};
            cout      <= co;
            ovf       <= carry ^ co;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add16.sv
// Scoreboard bench for serial_add16: directed corner cases plus random traffic.
module tb_serial_add16;
  localparam int W = 16;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         rnd_rdy = 1'b0, dir_rdy = 1'b1, rnd_bit = 1'b1;
  logic         out_ready;
  logic         in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] sum;

  assign out_ready = rnd_rdy ? rnd_bit : dir_rdy;

  serial_add16 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  acc_cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow by range check.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input int unsigned t);
    exp_t e;
    longint u  = longint'(x) + longint'(y) + longint'(ci);
    longint sv = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    e.sum     = W'(u);
    e.cout    = (u >= (64'sd1 <<< W));
    e.ovf     = (sv > ((64'sd1 <<< (W-1)) - 1)) || (sv < -(64'sd1 <<< (W-1)));
    e.acc_cyc = t;
    return e;
  endfunction

  // Monitor: compares every cycle out_valid is up, pops on handshake.
  logic ov_prev = 1'b0, post_hs = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
      post_hs = 1'b0;
    end else begin
      if (post_hs) begin
        chk("in_ready_after_out_hs", longint'(in_ready), 1);
        chk("out_valid_after_out_hs", longint'(out_valid), 0);
        post_hs = 1'b0;
      end
      if (in_valid && in_ready) bcnt = 0;
      else if (busy) bcnt++;
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          if (!ov_prev) begin
            chk("latency", longint'(cyc - q[0].acc_cyc), W);
            chk("busy_cycles", longint'(bcnt), W);
          end
          chk("sum", longint'(sum), longint'(q[0].sum));
          chk("cout", longint'(cout), longint'(q[0].cout));
          chk("ovf", longint'(ovf), longint'(q[0].ovf));
          chk("busy_in_done", longint'(busy), 0);
          if (out_ready) begin
            void'(q.pop_front());
            post_hs = 1'b1;
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int i;
    in_valid = 1'b1; a = x; b = y; cin = ci;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (i == 200) chk("in_ready_timeout", 0, 1);
    q.push_back(model(x, y, ci, cyc + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_timeout", longint'(q.size()), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_sum", longint'(sum), 0);
    chk("rst_cout", longint'({cout, ovf}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(16'h0001, 16'hFFFF, 1'b0); drain();
    send(16'h7FFF, 16'h0001, 1'b0); drain();
    send(16'hFFFF, 16'hFFFF, 1'b1); drain();
    send(16'h0000, 16'h0000, 1'b0); drain();
    send(16'h8000, 16'h8000, 1'b0); drain();
    send(16'hFFFF, 16'h0000, 1'b1); drain();

    // Back-pressure: result must hold while out_ready is low.
    dir_rdy = 1'b0;
    send(16'h1234, 16'h4321, 1'b1);
    begin
      int i;
      for (i = 0; i < 100 && !out_valid; i++) @(posedge clk);
      if (i == 100) chk("out_valid_timeout", 0, 1);
    end
    repeat (10) @(posedge clk);
    #1 dir_rdy = 1'b1;
    drain();

    // Operands presented mid-run must be ignored.
    send(16'h1234, 16'h1111, 1'b0);
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Abort with reset around bit 7, then a clean operation.
    send(16'h5555, 16'h0F0F, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_sum", longint'(sum), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h00FF, 16'h0001, 1'b0); drain();

    // Random back-to-back traffic with random back-pressure.
    rnd_rdy = 1'b1;
    for (int k = 0; k < 150; k++)
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    drain();
    rnd_rdy = 1'b0;

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
